// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encodings and default datapath width.
package alu_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SUBU = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
endpackage

// File: rtl/mips_alu_addsub.sv
// mips_alu_addsub: shared adder computing X+Y or X+~Y+1 with carry and signed overflow.
module mips_alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             signed_overflow
);
    logic [WIDTH-1:0] y_eff;
    assign y_eff = sub ? ~Y : Y;
    assign {carry_out, sum} = {1'b0, X} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    // Overflow when both addends share a sign the sum does not; y_eff folds in the subtract case.
    assign signed_overflow = (X[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit MIPS ALU with opcode mux, zero detect and valid qualifier.
module mips_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       ALUctr,
    output logic [WIDTH-1:0] R,
    output logic             Overflow,
    output logic             Zero,
    output logic             out_valid
);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             ovf;
    logic             ovf_flag;

    mips_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .X(X),
        .Y(Y),
        .sub(ALUctr[2]),
        .sum(sum),
        .carry_out(carry_out),
        .signed_overflow(ovf)
    );

    // Compares reuse the X-Y adder; signed less corrects the sign bit by overflow.
    always_comb begin
        result   = sum;
        ovf_flag = 1'b0;
        case (ALUctr)
            ALU_OR:   result = X | Y;
            ALU_AND:  result = X & Y;
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, ~carry_out};
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            ALU_ADD,
            ALU_SUB:  ovf_flag = ovf;
            default:  result = sum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            R         <= '0;
            Overflow  <= 1'b0;
            Zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                R        <= result;
                Overflow <= ovf_flag;
                Zero     <= (result == '0);
            end
        end
    end
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: randomized and directed checks of mips_alu against a behavioural model.
module tb_mips_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] X = '0;
    logic [31:0] Y = '0;
    logic [2:0]  ALUctr = '0;
    logic [31:0] R;
    logic        Overflow, Zero, out_valid;

    int passed = 0;
    int total = 0;

    logic [31:0] exp_r = '0;
    logic        exp_o = 1'b0, exp_z = 1'b0, exp_v = 1'b0, armed = 1'b0;

    mips_alu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .Y(Y), .ALUctr(ALUctr),
        .R(R), .Overflow(Overflow), .Zero(Zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Returns {overflow, result} from plain integer arithmetic.
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint s;
        logic [31:0] r = '0;
        logic o = 1'b0;
        case (op)
            3'd0: r = x + y;
            3'd1: begin s = sx + sy; r = x + y; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd2: r = x | y;
            3'd3: r = x & y;
            3'd4: r = x - y;
            3'd5: begin s = sx - sy; r = x - y; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd6: r = (x < y) ? 32'd1 : 32'd0;
            default: r = (sx < sy) ? 32'd1 : 32'd0;
        endcase
        return {o, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_r <= '0; exp_o <= 1'b0; exp_z <= 1'b0; exp_v <= 1'b0; armed <= 1'b1;
        end else begin
            exp_v <= in_valid;
            if (in_valid) begin
                {exp_o, exp_r} <= model(X, Y, ALUctr);
                exp_z <= (model(X, Y, ALUctr) & 33'h0_FFFF_FFFF) == 33'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model R", R, exp_r);
            chk("model Overflow", {31'd0, Overflow}, {31'd0, exp_o});
            chk("model Zero", {31'd0, Zero}, {31'd0, exp_z});
            chk("model out_valid", {31'd0, out_valid}, {31'd0, exp_v});
        end
    end

    task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] c,
                      input logic [31:0] r, input logic o, input logic z, input string name);
        @(negedge clk);
        in_valid = 1'b1; X = x; Y = y; ALUctr = c;
        @(negedge clk);
        chk({name, " R"}, R, r);
        chk({name, " Overflow"}, {31'd0, Overflow}, {31'd0, o});
        chk({name, " Zero"}, {31'd0, Zero}, {31'd0, z});
        chk({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; X = 32'h1234_5678; Y = 32'h1; ALUctr = 3'd0;
        repeat (2) @(negedge clk);
        chk("reset R", R, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("post-reset R", R, 32'd0);
        chk("post-reset Zero", {31'd0, Zero}, 32'd0);

        op(32'h2222_2222, 32'h1111_1111, 3'b001, 32'h3333_3333, 0, 0, "sweep ADD");
        op(32'h2222_2222, 32'h1111_1111, 3'b101, 32'h1111_1111, 0, 0, "sweep SUB");
        op(32'h2222_2222, 32'h1111_1111, 3'b111, 32'h0000_0000, 0, 1, "sweep SLT");
        op(32'h2222_2222, 32'h1111_1111, 3'b010, 32'h3333_3333, 0, 0, "sweep OR");
        op(32'h2222_2222, 32'h1111_1111, 3'b000, 32'h3333_3333, 0, 0, "sweep ADDU");
        op(32'h2222_2222, 32'h1111_1111, 3'b011, 32'h0000_0000, 0, 1, "sweep AND");

        op(32'h7FFF_FFFF, 32'h1, 3'b001, 32'h8000_0000, 1, 0, "ADD ovf");
        op(32'h7FFF_FFFF, 32'h1, 3'b000, 32'h8000_0000, 0, 0, "ADDU no ovf");
        op(32'h8000_0000, 32'h1, 3'b101, 32'h7FFF_FFFF, 1, 0, "SUB ovf");
        op(32'h8000_0000, 32'h1, 3'b100, 32'h7FFF_FFFF, 0, 0, "SUBU no ovf");
        op(32'h8000_0000, 32'h1, 3'b111, 32'h1, 0, 0, "SLT across ovf");
        op(32'h8000_0000, 32'h1, 3'b110, 32'h0, 0, 1, "SLTU big");
        op(32'h1, 32'hFFFF_FFFF, 3'b110, 32'h1, 0, 0, "SLTU small");
        op(32'h5, 32'h5, 3'b111, 32'h0, 0, 1, "SLT equal");
        op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101, 32'h0, 0, 1, "BEQ equal");
        op(32'hDEAD_BEEF, 32'hDEAD_BEEE, 3'b101, 32'h1, 0, 0, "BEQ differ");

        op(32'h0000_00F0, 32'h0000_000F, 3'b010, 32'h0000_00FF, 0, 0, "hold op");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; X = $urandom; Y = $urandom; ALUctr = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("hold R", R, 32'h0000_00FF);
            chk("hold out_valid", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            X = pick(); Y = pick(); ALUctr = 3'($urandom_range(0, 7));
            if (i == 200) rst = 1'b1;
            else rst = 1'b0;
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
